// File: rtl/tt_input_conditioner.sv
// Input conditioner: per-bit synchroniser, debounce and edge detect for the raw pads,
// plus one selectable saturating rising-edge event counter for bring-up.
//
// state      | meaning
// ST_STABLE  | synced level equals clean level, debounce counter idle at 0
// ST_PENDING | synced level differs from clean, counting consecutive mismatch cycles
module tt_input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 8,
    parameter int SEL_W           = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 ena_i,
    input  logic [WIDTH-1:0]     raw_in_i,
    output logic [WIDTH-1:0]     clean_out_o,
    output logic [WIDTH-1:0]     rise_pulse_o,
    output logic [WIDTH-1:0]     fall_pulse_o,
    input  logic [SEL_W-1:0]     evt_sel_i,
    input  logic                 evt_clr_i,
    output logic [CNT_WIDTH-1:0] evt_count_o,
    output logic                 evt_ovf_o
);

    localparam int DCW  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RP_W = 2 ** SEL_W;
    localparam logic [DCW-1:0] CNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     synced;
    db_state_e            state_q [WIDTH];
    logic [DCW-1:0]       cnt_q [WIDTH];
    logic [WIDTH-1:0]     clean_q;
    logic [WIDTH-1:0]     rise_q;
    logic [WIDTH-1:0]     fall_q;
    logic [CNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;
    logic                 evt_ovf_q, evt_ovf_d;
    logic [RP_W-1:0]      rise_pad;
    logic                 evt_hit;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= raw_in_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Acceptance updates clean and the matching pulse on the same edge, so the pulse
    // lines up with the first cycle the new level is visible.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int b = 0; b < WIDTH; b++) begin
                state_q[b] <= ST_STABLE;
                cnt_q[b]   <= '0;
            end
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                if (!ena_i) begin
                    state_q[b] <= ST_STABLE;
                    cnt_q[b]   <= '0;
                end else begin
                    case (state_q[b])
                        ST_STABLE: begin
                            if (synced[b] != clean_q[b]) begin
                                if (cnt_q[b] == CNT_LAST) begin
                                    clean_q[b] <= synced[b];
                                    rise_q[b]  <= synced[b];
                                    fall_q[b]  <= ~synced[b];
                                    cnt_q[b]   <= '0;
                                end else begin
                                    cnt_q[b]   <= cnt_q[b] + DCW'(1);
                                    state_q[b] <= ST_PENDING;
                                end
                            end else begin
                                cnt_q[b] <= '0;
                            end
                        end
                        ST_PENDING: begin
                            if (synced[b] == clean_q[b]) begin
                                cnt_q[b]   <= '0;
                                state_q[b] <= ST_STABLE;
                            end else if (cnt_q[b] == CNT_LAST) begin
                                clean_q[b] <= synced[b];
                                rise_q[b]  <= synced[b];
                                fall_q[b]  <= ~synced[b];
                                cnt_q[b]   <= '0;
                                state_q[b] <= ST_STABLE;
                            end else begin
                                cnt_q[b] <= cnt_q[b] + DCW'(1);
                            end
                        end
                        default: begin
                            cnt_q[b]   <= '0;
                            state_q[b] <= ST_STABLE;
                        end
                    endcase
                end
            end
        end
    end

    // Zero-padding makes selects at or beyond WIDTH read a constant 0.
    assign rise_pad = RP_W'(rise_q);
    assign evt_hit  = ena_i & rise_pad[evt_sel_i];

    always_comb begin
        evt_cnt_d = evt_cnt_q;
        evt_ovf_d = evt_ovf_q;
        if (evt_clr_i) begin
            evt_cnt_d = '0;
            evt_ovf_d = 1'b0;
        end else if (evt_hit) begin
            if (evt_cnt_q == '1) begin
                evt_ovf_d = 1'b1;
            end else begin
                evt_cnt_d = evt_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            evt_cnt_q <= '0;
            evt_ovf_q <= 1'b0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
            evt_ovf_q <= evt_ovf_d;
        end
    end

    assign clean_out_o  = clean_q;
    assign rise_pulse_o = rise_q;
    assign fall_pulse_o = fall_q;
    assign evt_count_o  = evt_cnt_q;
    assign evt_ovf_o    = evt_ovf_q;

endmodule

// File: tb/tb_tt_input_conditioner.sv
// Directed bench for tt_input_conditioner: latency, glitch rejection, simultaneous edges,
// counter saturation/clear, enable gating and mid-operation reset.
module tb_tt_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] raw;
    logic [2:0] sel;
    logic       clr;
    logic [7:0] clean;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] count;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    tt_input_conditioner dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .ena_i        (ena),
        .raw_in_i     (raw),
        .clean_out_o  (clean),
        .rise_pulse_o (rise),
        .fall_pulse_o (fall),
        .evt_sel_i    (sel),
        .evt_clr_i    (clr),
        .evt_count_o  (count),
        .evt_ovf_o    (ovf)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; raw = 8'h00; sel = 3'd0; clr = 1'b0;
        step(3);
        total++; if (clean !== 8'h00) begin bad++; $display("FAIL reset_clean got=%h want=00", clean); end
        total++; if (rise  !== 8'h00) begin bad++; $display("FAIL reset_rise got=%h want=00", rise); end
        total++; if (fall  !== 8'h00) begin bad++; $display("FAIL reset_fall got=%h want=00", fall); end
        total++; if (count !== 8'h00) begin bad++; $display("FAIL reset_count got=%h want=00", count); end
        total++; if (ovf   !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        raw = 8'h01;
        step(17);
        total++; if (clean !== 8'h00) begin bad++; $display("FAIL lat_clean_e17 got=%h want=00", clean); end
        total++; if (rise  !== 8'h00) begin bad++; $display("FAIL lat_rise_e17 got=%h want=00", rise); end
        step(1);
        total++; if (clean !== 8'h01) begin bad++; $display("FAIL lat_clean_e18 got=%h want=01", clean); end
        total++; if (rise  !== 8'h01) begin bad++; $display("FAIL lat_rise_e18 got=%h want=01", rise); end
        total++; if (count !== 8'd0)  begin bad++; $display("FAIL lat_count_e18 got=%0d want=0", count); end
        step(1);
        total++; if (rise  !== 8'h00) begin bad++; $display("FAIL lat_rise_e19 got=%h want=00", rise); end
        total++; if (count !== 8'd1)  begin bad++; $display("FAIL lat_count_e19 got=%0d want=1", count); end
    endtask

    task automatic test_glitch();
        int hold_len [2] = '{10, 15};
        for (int h = 0; h < 2; h++) begin
            raw = 8'h09;
            for (int i = 0; i < 40; i++) begin
                if (i == hold_len[h]) raw = 8'h01;
                step(1);
                total++; if (clean !== 8'h01) begin bad++; $display("FAIL glitch%0d_clean cyc=%0d got=%h want=01", hold_len[h], i, clean); end
                total++; if (rise  !== 8'h00) begin bad++; $display("FAIL glitch%0d_rise cyc=%0d got=%h want=00", hold_len[h], i, rise); end
                total++; if (fall  !== 8'h00) begin bad++; $display("FAIL glitch%0d_fall cyc=%0d got=%h want=00", hold_len[h], i, fall); end
            end
        end
        // Exactly 16 cycles high is long enough to be accepted.
        raw = 8'h09;
        for (int i = 1; i <= 18; i++) begin
            if (i == 17) raw = 8'h01;
            step(1);
            if (i == 17) begin
                total++; if (clean !== 8'h01) begin bad++; $display("FAIL hold16_clean_e17 got=%h want=01", clean); end
            end
        end
        total++; if (clean !== 8'h09) begin bad++; $display("FAIL hold16_clean_e18 got=%h want=09", clean); end
        total++; if (rise  !== 8'h08) begin bad++; $display("FAIL hold16_rise_e18 got=%h want=08", rise); end
        step(15);
        total++; if (clean !== 8'h09) begin bad++; $display("FAIL hold16_clean_e33 got=%h want=09", clean); end
        total++; if (fall  !== 8'h00) begin bad++; $display("FAIL hold16_fall_e33 got=%h want=00", fall); end
        step(1);
        total++; if (clean !== 8'h01) begin bad++; $display("FAIL hold16_clean_e34 got=%h want=01", clean); end
        total++; if (fall  !== 8'h08) begin bad++; $display("FAIL hold16_fall_e34 got=%h want=08", fall); end
        step(1);
        total++; if (fall  !== 8'h00) begin bad++; $display("FAIL hold16_fall_e35 got=%h want=00", fall); end
    endtask

    task automatic test_all_fall();
        raw = 8'hFF;
        step(20);
        total++; if (clean !== 8'hFF) begin bad++; $display("FAIL all_clean_high got=%h want=ff", clean); end
        total++; if (count !== 8'd1)  begin bad++; $display("FAIL all_count got=%0d want=1", count); end
        raw = 8'h00;
        step(17);
        total++; if (fall  !== 8'h00) begin bad++; $display("FAIL all_fall_e17 got=%h want=00", fall); end
        total++; if (clean !== 8'hFF) begin bad++; $display("FAIL all_clean_e17 got=%h want=ff", clean); end
        step(1);
        total++; if (fall  !== 8'hFF) begin bad++; $display("FAIL all_fall_e18 got=%h want=ff", fall); end
        total++; if (clean !== 8'h00) begin bad++; $display("FAIL all_clean_e18 got=%h want=00", clean); end
        step(1);
        total++; if (fall  !== 8'h00) begin bad++; $display("FAIL all_fall_e19 got=%h want=00", fall); end
    endtask

    task automatic test_saturation();
        sel = 3'd2;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        total++; if (count !== 8'd0) begin bad++; $display("FAIL sat_clr_count got=%0d want=0", count); end
        total++; if (ovf   !== 1'b0) begin bad++; $display("FAIL sat_clr_ovf got=%b want=0", ovf); end
        for (int n = 1; n <= 260; n++) begin
            raw = 8'h04;
            step(20);
            if (n == 255) begin
                total++; if (count !== 8'd255) begin bad++; $display("FAIL sat_count_255 got=%0d want=255", count); end
                total++; if (ovf   !== 1'b0)   begin bad++; $display("FAIL sat_ovf_255 got=%b want=0", ovf); end
            end
            if (n == 256) begin
                total++; if (count !== 8'd255) begin bad++; $display("FAIL sat_count_256 got=%0d want=255", count); end
                total++; if (ovf   !== 1'b1)   begin bad++; $display("FAIL sat_ovf_256 got=%b want=1", ovf); end
            end
            raw = 8'h00;
            step(20);
        end
        total++; if (count !== 8'd255) begin bad++; $display("FAIL sat_count_260 got=%0d want=255", count); end
        total++; if (ovf   !== 1'b1)   begin bad++; $display("FAIL sat_ovf_260 got=%b want=1", ovf); end
        raw = 8'h04;
        step(18);
        total++; if (rise !== 8'h04) begin bad++; $display("FAIL sat_pulse_for_clr got=%h want=04", rise); end
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        total++; if (count !== 8'd0) begin bad++; $display("FAIL clr_prio_count got=%0d want=0", count); end
        total++; if (ovf   !== 1'b0) begin bad++; $display("FAIL clr_prio_ovf got=%b want=0", ovf); end
        step(1);
        total++; if (count !== 8'd0) begin bad++; $display("FAIL clr_after_count got=%0d want=0", count); end
        raw = 8'h00;
        step(20);
    endtask

    task automatic test_ena_gate();
        ena = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 0)  raw = 8'h20;
            if (i == 3)  raw = 8'h00;
            if (i == 8)  raw = 8'h20;
            if (i == 11) raw = 8'h00;
            if (i == 13) raw = 8'h20;
            step(1);
            total++; if (clean !== 8'h00) begin bad++; $display("FAIL ena_clean cyc=%0d got=%h want=00", i, clean); end
            total++; if (rise  !== 8'h00) begin bad++; $display("FAIL ena_rise cyc=%0d got=%h want=00", i, rise); end
            total++; if (fall  !== 8'h00) begin bad++; $display("FAIL ena_fall cyc=%0d got=%h want=00", i, fall); end
        end
        ena = 1'b1;
        step(15);
        total++; if (clean !== 8'h00) begin bad++; $display("FAIL ena_clean_e15 got=%h want=00", clean); end
        step(1);
        total++; if (clean !== 8'h20) begin bad++; $display("FAIL ena_clean_e16 got=%h want=20", clean); end
        total++; if (rise  !== 8'h20) begin bad++; $display("FAIL ena_rise_e16 got=%h want=20", rise); end
        step(1);
        total++; if (rise  !== 8'h00) begin bad++; $display("FAIL ena_rise_e17 got=%h want=00", rise); end
        total++; if (count !== 8'd0)  begin bad++; $display("FAIL ena_count got=%0d want=0", count); end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 7; n++) begin
            raw = 8'h24;
            step(20);
            raw = 8'h20;
            step(20);
        end
        total++; if (count !== 8'd7) begin bad++; $display("FAIL rst_pre_count got=%0d want=7", count); end
        raw = 8'h24;
        step(12);
        rst_n = 1'b0;
        #1;
        total++; if (clean !== 8'h00) begin bad++; $display("FAIL rst_mid_clean got=%h want=00", clean); end
        total++; if (rise  !== 8'h00) begin bad++; $display("FAIL rst_mid_rise got=%h want=00", rise); end
        total++; if (fall  !== 8'h00) begin bad++; $display("FAIL rst_mid_fall got=%h want=00", fall); end
        total++; if (count !== 8'd0)  begin bad++; $display("FAIL rst_mid_count got=%0d want=0", count); end
        total++; if (ovf   !== 1'b0)  begin bad++; $display("FAIL rst_mid_ovf got=%b want=0", ovf); end
        step(1);
        rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step(1);
            total++; if (clean !== 8'h00) begin bad++; $display("FAIL rst_re_clean e=%0d got=%h want=00", i, clean); end
            total++; if (rise  !== 8'h00) begin bad++; $display("FAIL rst_re_rise e=%0d got=%h want=00", i, rise); end
            total++; if (fall  !== 8'h00) begin bad++; $display("FAIL rst_re_fall e=%0d got=%h want=00", i, fall); end
        end
        step(1);
        total++; if (clean !== 8'h24) begin bad++; $display("FAIL rst_re_clean_e18 got=%h want=24", clean); end
        total++; if (rise  !== 8'h24) begin bad++; $display("FAIL rst_re_rise_e18 got=%h want=24", rise); end
        step(1);
        total++; if (count !== 8'd1)  begin bad++; $display("FAIL rst_re_count got=%0d want=1", count); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_all_fall();
        test_saturation();
        test_ena_gate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_input_conditioner.md
Name: tt_input_conditioner

Overview:
- Input-conditioning stage directly upstream of the top-level logic.
- Takes raw asynchronous pad inputs (the dedicated ui_in bits), then synchronises, debounces and edge-detects them, so downstream gates see clean, glitch-free levels.
- Also provides one selectable rising-edge event counter, used for bring-up and characterisation of the chip's inputs.

Parameters:
- WIDTH, 8, number of conditioned input bits.
- SYNC_STAGES, 2, flops in each synchroniser chain (minimum 2).
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised level must hold before it is accepted (minimum 1).
- CNT_WIDTH, 8, width of the event counter.
- SEL_W, 3, width of the channel select; must satisfy 2^SEL_W >= WIDTH.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design enable, high when the project is selected.
- raw_in  input  WIDTH  raw asynchronous inputs.
- clean_out  output  WIDTH  debounced levels.
- rise_pulse  output  WIDTH  one-cycle pulse per bit on an accepted 0->1.
- fall_pulse  output  WIDTH  one-cycle pulse per bit on an accepted 1->0.
- evt_sel  input  SEL_W  selects which bit's rise_pulse is counted.
- evt_clr  input  1  synchronous clear of counter and overflow flag.
- evt_count  output  CNT_WIDTH  saturating count of rising events.
- evt_ovf  output  1  sticky flag, set when an increment is attempted while the counter is at maximum.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous assert and synchronous-safe deassert, taken from rst_n as given.
  - rst_n low clears immediately: all sync flops, debounce counters, clean_out, rise_pulse, fall_pulse, evt_count and evt_ovf go to 0.
  - Reset mid-operation aborts any debounce in progress. No pulse is generated by the reset itself.
- Synchroniser:
  - Each bit passes through SYNC_STAGES flops. The last stage is the synced level.
  - The synchroniser runs regardless of ena.
- Debounce, per bit, a two-state machine:
  - STABLE (synced == clean):
    - Counter is held at 0.
  - PENDING (synced != clean):
    - Each edge with mismatch: cnt <= cnt+1.
    - Edge with mismatch and cnt == DEBOUNCE_CYCLES-1: clean <= synced, cnt <= 0, return to STABLE.
    - synced returns to clean before acceptance: cnt <= 0, return to STABLE, clean unchanged. A glitch shorter than DEBOUNCE_CYCLES never propagates.
  - Counter width is clog2(DEBOUNCE_CYCLES)+1. The counter never wraps.
- Latency:
  - A raw change settled before edge 1 appears on clean_out after edge SYNC_STAGES+DEBOUNCE_CYCLES. With defaults that is edge 18.
- Edge pulses:
  - rise_pulse and fall_pulse are registered and asserted for exactly one cycle, coincident with the first cycle clean_out shows the new value.
  - Bits are independent; several may pulse in the same cycle.
- ena low:
  - Debounce counters are held at 0 and clean_out is frozen.
  - Pulses are 0 and the event counter is held.
  - When ena rises, a bit whose synced level differs from clean restarts its debounce from 0.
- Event counter:
  - On each edge where rise_pulse[evt_sel] == 1, evt_count increments, so it updates one cycle after the pulse.
  - At the maximum value (2^CNT_WIDTH-1) the count saturates and evt_ovf sets. evt_ovf stays set until cleared.
  - evt_clr == 1 at an edge sets evt_count <= 0 and evt_ovf <= 0. evt_clr has priority over a simultaneous increment.
  - Changing evt_sel does not clear the count; the new channel is counted from the next edge.
  - An evt_sel value >= WIDTH counts nothing.
- Power-up: clean_out resets to 0. An input held high through reset yields a rise_pulse SYNC_STAGES+DEBOUNCE_CYCLES cycles after rst_n release (with ena high).

Test Plan:
- Reset, then raw_in=0x01 held, ena=1: clean_out[0] rises on edge 18; rise_pulse=0x01 for exactly one cycle; evt_sel=0 gives evt_count=1 one cycle later.
- raw_in[3] glitch high for 10 cycles then low: clean_out, rise_pulse and fall_pulse stay 0x00 throughout. A 16-cycle hold is accepted; a 15-cycle hold is rejected.
- raw_in=0xFF to 0x00 simultaneously after settling: fall_pulse=0xFF for one cycle, 18 cycles after the change; clean_out becomes 0x00.
- 260 debounced rising edges on bit 2, evt_sel=2, CNT_WIDTH=8: evt_count saturates at 255 and evt_ovf=1. evt_clr coincident with a pulse gives evt_count=0 and evt_ovf=0.
- ena=0 while raw_in[5] toggles and settles high: clean_out frozen, no pulses. After ena=1, clean_out[5] rises 16 cycles later.
- rst_n low for one cycle during a debounce (cnt=10) and during evt_count=7: all outputs read 0 at once. After release, debounce restarts with full latency and no spurious pulse.
